// File: rtl/pe_weight_loader.sv
// Weight loader for one PE row: fetches a kernel from the weight buffer, unpacks 8-bit or packed 4-bit
// weights into a sign-extended 5*5 / 3*3 tap set, and double-buffers it against the consumer.
module pe_weight_loader #(
    parameter int IN_BYTES = 4,
    parameter int ADDR_W   = 9,
    parameter int OUT_W    = 8,
    parameter int MAX_TAPS = 25
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      kernel_mode,
    input  logic                      bit_mode,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [8*IN_BYTES-1:0]     rd_data,
    output logic                      wt_valid,
    input  logic                      wt_ready,
    output logic [MAX_TAPS*OUT_W-1:0] wt_data,
    output logic                      busy,
    output logic                      done
);

    localparam int N_MAX = (MAX_TAPS + IN_BYTES - 1) / IN_BYTES;
    localparam int NBUF  = N_MAX * IN_BYTES;
    localparam int CNT_W = $clog2(N_MAX + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, XFER = 2'd3} state_t;

    state_t                    state_r, state_nx;
    logic                      start_go_s, move_s;
    logic                      km_r, bm_r;
    logic [CNT_W-1:0]          rd_cnt_r, last_r, cap_idx_r;
    logic                      cap_r;
    logic                      rd_en_r, wt_valid_r, done_r;
    logic [ADDR_W-1:0]         rd_addr_r;
    logic [7:0]                byte_buf [NBUF];
    logic [MAX_TAPS*OUT_W-1:0] asm_taps_s, wt_data_r;

    function automatic logic [CNT_W-1:0] words_needed(input logic km, input logic bm);
        int taps;
        int nbytes;
        taps   = km ? MAX_TAPS : 9;
        nbytes = bm ? (taps + 1) / 2 : taps;
        return CNT_W'((nbytes + IN_BYTES - 1) / IN_BYTES);
    endfunction

    function automatic logic [OUT_W-1:0] sext8(input logic [7:0] v);
        return OUT_W'($signed(v));
    endfunction

    function automatic logic [OUT_W-1:0] sext4(input logic [3:0] v);
        return OUT_W'($signed(v));
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; the output move waits for a free or draining output register
    always_comb begin
        state_nx   = state_r;
        start_go_s = 1'b0;
        move_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx   = FETCH;
                    start_go_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            FETCH: begin
                if (rd_cnt_r == last_r) begin
                    state_nx = DRAIN;
                end else begin
                    state_nx = FETCH;
                end
            end
            DRAIN: state_nx = XFER;
            XFER: begin
                if (!wt_valid_r || wt_ready) begin
                    move_s   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = XFER;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read sequencer: latches the request and issues N back-to-back reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            km_r      <= 1'b0;
            bm_r      <= 1'b0;
            last_r    <= '0;
            rd_cnt_r  <= '0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= '0;
        end else if (start_go_s) begin
            km_r      <= kernel_mode;
            bm_r      <= bit_mode;
            last_r    <= words_needed(kernel_mode, bit_mode) - CNT_W'(1);
            rd_cnt_r  <= '0;
            rd_en_r   <= 1'b1;
            rd_addr_r <= base_addr;
        end else if (state_r == FETCH) begin
            if (rd_cnt_r == last_r) begin
                rd_en_r <= 1'b0;
            end else begin
                rd_cnt_r  <= rd_cnt_r + CNT_W'(1);
                rd_addr_r <= rd_addr_r + ADDR_W'(1);
            end
        end else begin
            rd_en_r <= 1'b0;
        end
    end

    // Capture pipeline: data for the read issued in one cycle lands in the byte buffer the next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_r     <= 1'b0;
            cap_idx_r <= '0;
            for (int k = 0; k < NBUF; k++) begin
                byte_buf[k] <= 8'd0;
            end
        end else begin
            cap_r     <= rd_en_r;
            cap_idx_r <= rd_cnt_r;
            if (cap_r) begin
                for (int w = 0; w < N_MAX; w++) begin
                    if (cap_idx_r == CNT_W'(w)) begin
                        for (int b = 0; b < IN_BYTES; b++) begin
                            byte_buf[w*IN_BYTES+b] <= rd_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Unpack the byte stream into taps; 3*3 kernels leave taps 9 and up at zero
    always_comb begin
        asm_taps_s = '0;
        for (int i = 0; i < MAX_TAPS; i++) begin
            if (!km_r && i >= 9) begin
                asm_taps_s[i*OUT_W +: OUT_W] = '0;
            end else if (bm_r) begin
                if (i % 2 == 1) begin
                    asm_taps_s[i*OUT_W +: OUT_W] = sext4(byte_buf[i/2][7:4]);
                end else begin
                    asm_taps_s[i*OUT_W +: OUT_W] = sext4(byte_buf[i/2][3:0]);
                end
            end else begin
                asm_taps_s[i*OUT_W +: OUT_W] = sext8(byte_buf[i]);
            end
        end
    end

    // Output register and valid/ready handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wt_valid_r <= 1'b0;
            wt_data_r  <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= move_s;
            if (move_s) begin
                wt_valid_r <= 1'b1;
                wt_data_r  <= asm_taps_s;
            end else if (wt_ready) begin
                wt_valid_r <= 1'b0;
            end else begin
                wt_valid_r <= wt_valid_r;
            end
        end
    end

    assign rd_en    = rd_en_r;
    assign rd_addr  = rd_addr_r;
    assign wt_valid = wt_valid_r;
    assign wt_data  = wt_data_r;
    assign done     = done_r;
    assign busy     = (state_r != IDLE);

endmodule
